stream_disperse: RTL and testbench
==================================

# stream_disperse

Downstream consumer of the merged memory readout stream. Takes the 52-bit tagged word stream plus its `valid` bit and `done`, and demultiplexes each word back into one of 12 destination memories (L1L2_1..4, L3L4_1..4, L5L6_1..4). It generates per-memory write strobes and addresses, counts items per memory, and publishes the per-memory item counts at end of event. Those counts are the `number_in` values for the next readout stage.

## Interface
- `NMEM`, 12: number of destination memories; tag values 0..NMEM-1 are legal.
- `AW`, 6: address / item-count width per memory.
- `clk`  in  1: processing clock.
- `reset`  in  1: asynchronous, active-low reset.
- `new_event`  in  1: single-cycle pulse that starts a new event.
- `BX`  in  3: bunch crossing of the event; sampled on `new_event`.
- `mem_dat_stream`  in  52: merged word. [51:48] memory tag, [47:45] BX, [44:0] payload.
- `valid`  in  1: `mem_dat_stream` holds a valid word this cycle.
- `done_in`  in  1: upstream has no more data (level).
- `wr_en`  out  NMEM: one-hot write strobe.
- `wr_addr`  out  AW: write address for the strobed memory.
- `wr_page`  out  3: high address bits; the latched event BX.
- `wr_dat`  out  45: payload to write.
- `number_out`  out  NMEM*AW: published per-memory counts; memory k occupies [k*AW +: AW].
- `counts_valid`  out  1: one-cycle pulse when `number_out` updates.
- `truncated`  out  1: last published counts came from an event cut short by `new_event`.
- `err_flags`  out  3: sticky error bits. [0] bad tag, [1] BX mismatch, [2] memory overflow.

## Operation
- FSM states: IDLE, ACTIVE, DRAIN, PUBLISH.
- After reset, state is IDLE.
  - All outputs are 0.
  - All counts and latched BX are 0.
- Any state, `new_event`:
  - Latch `BX` into `wr_page`.
  - Clear all 12 counters and `err_flags`.
  - Go to ACTIVE.
  - If the prior state was ACTIVE or DRAIN, first publish the current counts (`counts_valid`=1, `truncated`=1) in that same cycle.
- ACTIVE: a word is sampled on every `valid`=1. Decode per word:
  - tag >= NMEM: drop the word, set `err_flags[0]`.
  - word BX != latched BX: drop the word, set `err_flags[1]`.
  - count[tag] == 2^AW-1: drop the word, set `err_flags[2]`. The counter saturates and does not wrap.
  - Otherwise: write at address count[tag], then count[tag] += 1.
- ACTIVE to DRAIN when `done_in`=1 and `valid`=0 in the same cycle.
- DRAIN: one cycle so the last write retires, then go to PUBLISH.
- PUBLISH: one cycle.
  - `number_out` takes the counters.
  - `counts_valid`=1, `truncated`=0.
  - Then go to IDLE.
- IDLE ignores `valid`. A word arriving while IDLE sets no flag.
- A `valid` word in the same cycle as `new_event` is dropped. It is not counted in either event.
- `done_in` asserted before any word arrives leads to publishing all-zero counts.

## Timing
- Two-stage pipeline: input register, then decode/write.
  - `valid` sampled at edge t gives `wr_en`/`wr_addr`/`wr_dat` registered at edge t+1.
  - Fully pipelined: back-to-back `valid` words produce back-to-back writes, including to the same memory with consecutive addresses.
- `wr_en` is at most one-hot and is 0 for any dropped word.
- `counts_valid` asserts 2 cycles after the `done_in` sample (DRAIN, then PUBLISH).
- `number_out` holds its value until the next publish. Reset clears it.
- `err_flags` update in the same cycle as the suppressed write.

## Test plan
- Reset, then `new_event` with BX=5. Send 3 words tagged 0, 1 word tagged 11, all BX=5, then `done_in` -> `wr_en[0]` pulses at addresses 0,1,2; `wr_en[11]` pulses at address 0; `wr_page`=5; `counts_valid` 2 cycles after done; count0=3, count11=1, all others 0; `truncated`=0.
- Back-to-back `valid` for 8 cycles, alternating tags 3 and 4 -> 8 consecutive `wr_en` cycles; addresses 0..3 on each memory; counts 4 and 4.
- Word with tag 12, then a word with BX=2 during a BX=5 event -> no `wr_en`; `err_flags`=3'b011; counts unchanged.
- 64 words to tag 7 -> writes at addresses 0..62; 64th word dropped; count7=63; `err_flags[2]`=1.
- `new_event` mid-event after 2 words to tag 0 -> same-cycle publish with count0=2, `truncated`=1; counters clear; the next word to tag 0 is written at address 0.
- Assert `reset` low during ACTIVE -> all outputs 0 immediately; state IDLE; `valid` words ignored until `new_event`.

Source files
------------

// File: rtl/stream_disperse.sv
// ============================================================================
// Module   : stream_disperse
// Purpose  : Demultiplex the merged tagged word stream into per-memory writes
//            and publish per-memory item counts at the end of each event.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_disperse #(
  parameter int NMEM = 12,
  parameter int AW   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_event,
  input  logic [2:0]           BX,
  input  logic [51:0]          mem_dat_stream,
  input  logic                 valid,
  input  logic                 done_in,
  output logic [NMEM-1:0]      wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [2:0]           wr_page,
  output logic [44:0]          wr_dat,
  output logic [NMEM*AW-1:0]   number_out,
  output logic                 counts_valid,
  output logic                 truncated,
  output logic [2:0]           err_flags
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_DRAIN   = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic              r_in_valid;
  logic [51:0]       r_in_dat;
  logic [2:0]        r_bx;
  logic [AW-1:0]     r_count [NMEM];
  logic [NMEM*AW-1:0] w_count_flat;

  logic [3:0]        w_tag;
  logic [2:0]        w_word_bx;
  logic              w_bad_tag;
  logic              w_bad_bx;
  logic [AW-1:0]     w_cur;
  logic              w_full;
  logic              w_do_write;
  logic              w_publish;
  logic              w_trunc;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    w_trunc     = 1'b0;
    case (r_state)
      S_IDLE:    w_state_nxt = S_IDLE;
      S_ACTIVE:  if (done_in && !valid) w_state_nxt = S_DRAIN;
      S_DRAIN:   w_state_nxt = S_PUBLISH;
      S_PUBLISH: begin
        w_state_nxt = S_IDLE;
        w_publish   = 1'b1;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
    if (new_event) begin
      w_state_nxt = S_ACTIVE;
      // An unfinished event is published as truncated before being cleared
      if (r_state == S_ACTIVE || r_state == S_DRAIN) begin
        w_publish = 1'b1;
        w_trunc   = 1'b1;
      end
    end
  end

  // -------------------------------------------------------- input stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_valid <= 1'b0;
      r_in_dat   <= '0;
    end else begin
      r_in_valid <= valid && (r_state == S_ACTIVE) && !new_event;
      r_in_dat   <= mem_dat_stream;
    end
  end

  // ------------------------------------------------------- decode stage
  always_comb begin
    w_tag      = r_in_dat[51:48];
    w_word_bx  = r_in_dat[47:45];
    w_bad_tag  = (w_tag > 4'(NMEM - 1));
    w_bad_bx   = (w_word_bx != r_bx);
    w_cur      = w_bad_tag ? '0 : r_count[w_tag];
    w_full     = &w_cur;
    w_do_write = r_in_valid && !new_event && !w_bad_tag && !w_bad_bx && !w_full;
  end

  always_comb begin
    w_count_flat = '0;
    for (int k = 0; k < NMEM; k++) w_count_flat[k*AW +: AW] = r_count[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bx      <= '0;
      wr_en     <= '0;
      wr_addr   <= '0;
      wr_dat    <= '0;
      err_flags <= '0;
      for (int k = 0; k < NMEM; k++) r_count[k] <= '0;
    end else if (new_event) begin
      // Any word still in the decode stage belongs to neither event
      r_bx      <= BX;
      wr_en     <= '0;
      err_flags <= '0;
      for (int k = 0; k < NMEM; k++) r_count[k] <= '0;
    end else begin
      wr_en <= w_do_write ? (NMEM'(1) << w_tag) : '0;
      if (w_do_write) begin
        wr_addr        <= w_cur;
        wr_dat         <= r_in_dat[44:0];
        r_count[w_tag] <= w_cur + AW'(1);
      end
      if (r_in_valid) begin
        if (w_bad_tag)     err_flags[0] <= 1'b1;
        else if (w_bad_bx) err_flags[1] <= 1'b1;
        else if (w_full)   err_flags[2] <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ publish
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      number_out   <= '0;
      counts_valid <= 1'b0;
      truncated    <= 1'b0;
    end else begin
      counts_valid <= w_publish;
      if (w_publish) begin
        number_out <= w_count_flat;
        truncated  <= w_trunc;
      end
    end
  end

  assign wr_page = r_bx;

endmodule

`default_nettype wire

// File: tb/tb_stream_disperse.sv
// ============================================================================
// Module   : tb_stream_disperse
// Purpose  : Directed self-checking bench for stream_disperse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_disperse;

  localparam int NMEM = 12;
  localparam int AW   = 6;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                new_event = 1'b0;
  logic [2:0]          BX = '0;
  logic [51:0]         mem_dat_stream = '0;
  logic                valid = 1'b0;
  logic                done_in = 1'b0;
  logic [NMEM-1:0]     wr_en;
  logic [AW-1:0]       wr_addr;
  logic [2:0]          wr_page;
  logic [44:0]         wr_dat;
  logic [NMEM*AW-1:0]  number_out;
  logic                counts_valid;
  logic                truncated;
  logic [2:0]          err_flags;

  stream_disperse #(.NMEM(NMEM), .AW(AW)) dut (
    .clk(clk), .reset(reset), .new_event(new_event), .BX(BX),
    .mem_dat_stream(mem_dat_stream), .valid(valid), .done_in(done_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_page(wr_page), .wr_dat(wr_dat),
    .number_out(number_out), .counts_valid(counts_valid),
    .truncated(truncated), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write / publish monitor, sampled 1 ns after each rising edge
  int              cyc = 0;
  int              log_mem[$];
  int              log_addr[$];
  int              log_cyc[$];
  logic [44:0]     log_dat[$];
  int              pub_cnt = 0;
  int              pub_cyc = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (wr_en != '0) begin
      int m;
      m = -1;
      if ($onehot(wr_en))
        for (int k = 0; k < NMEM; k++) if (wr_en[k]) m = k;
      log_mem.push_back(m);
      log_addr.push_back(int'(wr_addr));
      log_dat.push_back(wr_dat);
      log_cyc.push_back(cyc);
    end
    if (counts_valid) begin
      pub_cnt++;
      pub_cyc = cyc;
    end
  end

  task automatic clear_log();
    log_mem.delete(); log_addr.delete(); log_dat.delete(); log_cyc.delete();
  endtask

  task automatic drive(input logic nev, input logic [2:0] bx, input logic vld,
                       input logic dn, input logic [3:0] tag, input logic [2:0] wbx,
                       input logic [44:0] pl);
    @(negedge clk);
    new_event      = nev;
    BX             = bx;
    valid          = vld;
    done_in        = dn;
    mem_dat_stream = {tag, wbx, pl};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 3'd0, 45'd0);
  endtask

  task automatic start_event(input logic [2:0] bx);
    drive(1'b1, bx, 1'b0, 1'b0, 4'd0, 3'd0, 45'd0);
  endtask

  task automatic send(input logic [3:0] tag, input logic [2:0] wbx, input logic [44:0] pl);
    drive(1'b0, 3'd0, 1'b1, 1'b0, tag, wbx, pl);
  endtask

  // Drives done; returns the cycle number of the edge that samples it
  task automatic finish_event(output int dcyc);
    drive(1'b0, 3'd0, 1'b0, 1'b1, 4'd0, 3'd0, 45'd0);
    dcyc = cyc + 1;
  endtask

  function automatic logic [NMEM*AW-1:0] counts(input int m0, input int c0,
                                                 input int m1, input int c1);
    logic [NMEM*AW-1:0] v;
    v = '0;
    if (m0 >= 0) v[m0*AW +: AW] = AW'(c0);
    if (m1 >= 0) v[m1*AW +: AW] = AW'(c1);
    return v;
  endfunction

  initial begin
    int dcyc;
    int p0;

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_number", number_out, 0);
    chk("rst_misc", {counts_valid, truncated, err_flags, wr_page}, 0);
    reset = 1'b1;
    idle(2);

    // ---- basic event: 3 words to mem 0, 1 to mem 11
    clear_log();
    p0 = pub_cnt;
    start_event(3'd5);
    send(4'd0, 3'd5, 45'h100);
    send(4'd0, 3'd5, 45'h101);
    send(4'd0, 3'd5, 45'h102);
    send(4'd11, 3'd5, 45'h1AB);
    finish_event(dcyc);
    idle(5);
    chk("t1_nwrites", log_mem.size(), 4);
    if (log_mem.size() == 4) begin
      chk("t1_w0", {log_mem[0], log_addr[0], 19'd0, log_dat[0]}, {32'd0,  32'd0, 19'd0, 45'h100});
      chk("t1_w1", {log_mem[1], log_addr[1], 19'd0, log_dat[1]}, {32'd0,  32'd1, 19'd0, 45'h101});
      chk("t1_w2", {log_mem[2], log_addr[2], 19'd0, log_dat[2]}, {32'd0,  32'd2, 19'd0, 45'h102});
      chk("t1_w3", {log_mem[3], log_addr[3], 19'd0, log_dat[3]}, {32'd11, 32'd0, 19'd0, 45'h1AB});
    end
    chk("t1_page", wr_page, 3'd5);
    chk("t1_pubcnt", pub_cnt - p0, 1);
    chk("t1_pub_lat", pub_cyc - dcyc, 2);
    chk("t1_counts", number_out, counts(0, 3, 11, 1));
    chk("t1_trunc", truncated, 0);
    chk("t1_err", err_flags, 0);

    // ---- back-to-back alternating tags 3 and 4
    clear_log();
    start_event(3'd3);
    for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 4'd3 : 4'd4, 3'd3, 45'(i));
    p0 = cyc + 1;  // edge that samples the last word
    finish_event(dcyc);
    idle(5);
    chk("t2_nwrites", log_mem.size(), 8);
    if (log_mem.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_mem",  log_mem[i],  (i % 2 == 0) ? 3 : 4);
        chk("t2_addr", log_addr[i], i / 2);
        chk("t2_dat",  log_dat[i],  45'(i));
      end
      chk("t2_span", log_cyc[7] - log_cyc[0], 7);
      chk("t2_lat", log_cyc[7] - p0, 1);
    end
    chk("t2_counts", number_out, counts(3, 4, 4, 4));
    chk("t2_page", wr_page, 3'd3);

    // ---- bad tag and BX mismatch
    clear_log();
    start_event(3'd5);
    send(4'd12, 3'd5, 45'h5);
    send(4'd2, 3'd2, 45'h6);
    idle(3);
    chk("t3_nwrites", log_mem.size(), 0);
    chk("t3_err", err_flags, 3'b011);
    finish_event(dcyc);
    idle(4);
    chk("t3_counts", number_out, 0);
    chk("t3_err_sticky", err_flags, 3'b011);

    // ---- overflow on mem 7
    clear_log();
    start_event(3'd1);
    for (int i = 0; i < 64; i++) send(4'd7, 3'd1, 45'(i + 1000));
    idle(3);
    chk("t4_nwrites", log_mem.size(), 63);
    for (int i = 0; i < log_mem.size(); i++) begin
      chk("t4_mem",  log_mem[i], 7);
      chk("t4_addr", log_addr[i], i);
    end
    chk("t4_err", err_flags, 3'b100);
    finish_event(dcyc);
    idle(4);
    chk("t4_counts", number_out, counts(7, 63, -1, 0));

    // ---- truncation by new_event; a word on the new_event cycle is dropped
    clear_log();
    start_event(3'd2);
    send(4'd0, 3'd2, 45'hA0);
    send(4'd0, 3'd2, 45'hA1);
    idle(1);
    p0 = pub_cnt;
    drive(1'b1, 3'd2, 1'b1, 1'b0, 4'd0, 3'd2, 45'hDD);
    idle(1);
    chk("t5_pubcnt", pub_cnt - p0, 1);
    chk("t5_counts", number_out, counts(0, 2, -1, 0));
    chk("t5_trunc", truncated, 1);
    clear_log();
    send(4'd0, 3'd2, 45'hB0);
    idle(2);
    chk("t5_nwrites", log_mem.size(), 1);
    if (log_mem.size() == 1)
      chk("t5_addr", {log_mem[0], log_addr[0]}, {32'd0, 32'd0});
    finish_event(dcyc);
    idle(4);
    chk("t5_counts2", number_out, counts(0, 1, -1, 0));
    chk("t5_trunc2", truncated, 0);

    // ---- asynchronous reset during ACTIVE
    start_event(3'd6);
    send(4'd1, 3'd6, 45'h77);
    send(4'd1, 3'd6, 45'h78);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_wr_en", wr_en, 0);
    chk("t6_number", number_out, 0);
    chk("t6_misc", {counts_valid, truncated, err_flags, wr_page}, 0);
    @(negedge clk);
    reset = 1'b1;
    clear_log();
    p0 = pub_cnt;
    for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 1'b1, 1'b1, 4'(12 + i % 2), 3'd0, 45'(i));
    idle(4);
    chk("t6_nwrites", log_mem.size(), 0);
    chk("t6_pubcnt", pub_cnt - p0, 0);
    chk("t6_err", err_flags, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
